// File: rtl/divisor_freq_prog.sv
// Programmable clock-enable generator for the MIPS core.
// It supports pulse, square-wave and push-button single-step modes, and the divisor can be reloaded at run time.
module divisor_freq_prog #(
    parameter int          WIDTH     = 24,
    parameter int unsigned DIV_RESET = 1562500
) (
    input  logic             clock_fpga,
    input  logic             congela_sw,
    input  logic             congela,
    input  logic             halt,
    input  logic [1:0]       mode,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    input  logic             step,
    output logic             new_clock,
    output logic             led_pc,
    output logic             div_err
);

    typedef enum logic [1:0] {
        MODE_PULSE     = 2'b00,
        MODE_SQUARE    = 2'b01,
        MODE_STEP      = 2'b10,
        MODE_PULSE_ALT = 2'b11
    } mode_t;

    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] div_q, div_n;
    logic             sq, sq_n;
    logic             step_d;
    logic [1:0]       mode_q;
    logic             new_clock_n, led_pc_n, div_err_n;
    logic             terminal;

    assign terminal = (cnt == div_q);

    // Next-state logic. It applies the controls in priority order: freeze, load, mode change, halt, then the mode itself.
    always_comb begin
        cnt_n       = cnt;
        div_n       = div_q;
        sq_n        = sq;
        new_clock_n = 1'b0;
        led_pc_n    = 1'b0;
        div_err_n   = 1'b0;
        if (congela) begin
            cnt_n = '0;
            sq_n  = 1'b0;
        end else if (div_load) begin
            // A zero divisor is rejected. The count and phase are left untouched for that cycle.
            if (div_value != '0) begin
                div_n = div_value;
                cnt_n = '0;
                sq_n  = 1'b0;
            end else begin
                div_err_n = 1'b1;
            end
        end else if (mode != mode_q) begin
            cnt_n = '0;
            sq_n  = 1'b0;
        end else if (halt) begin
            sq_n = 1'b0;
        end else begin
            case (mode_t'(mode))
                MODE_STEP: begin
                    cnt_n       = '0;
                    sq_n        = 1'b0;
                    new_clock_n = step & ~step_d;
                end
                MODE_SQUARE: begin
                    if (terminal) begin
                        cnt_n       = '0;
                        sq_n        = ~sq;
                        new_clock_n = ~sq;
                    end else begin
                        cnt_n       = cnt + 1'b1;
                        new_clock_n = sq;
                        led_pc_n    = 1'b1;
                    end
                end
                default: begin
                    if (terminal) begin
                        cnt_n       = '0;
                        new_clock_n = 1'b1;
                    end else begin
                        cnt_n    = cnt + 1'b1;
                        led_pc_n = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers.
    // step_d and mode_q are sampled on every edge, so a step edge that arrives while the block is blocked is consumed.
    always_ff @(posedge clock_fpga) begin
        if (congela_sw) begin
            cnt       <= '0;
            div_q     <= WIDTH'(DIV_RESET);
            sq        <= 1'b0;
            step_d    <= 1'b0;
            mode_q    <= 2'b00;
            new_clock <= 1'b0;
            led_pc    <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            div_q     <= div_n;
            sq        <= sq_n;
            step_d    <= step;
            mode_q    <= mode;
            new_clock <= new_clock_n;
            led_pc    <= led_pc_n;
            div_err   <= div_err_n;
        end
    end

endmodule

// File: tb/tb_divisor_freq_prog.sv
// Directed testbench for divisor_freq_prog with WIDTH=4 and DIV_RESET=3.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_divisor_freq_prog;

    localparam int W = 4;

    logic         clock_fpga = 1'b0;
    logic         congela_sw, congela, halt, div_load, step;
    logic [1:0]   mode;
    logic [W-1:0] div_value;
    logic         new_clock, led_pc, div_err;

    int errors = 0;
    int checks = 0;

    divisor_freq_prog #(.WIDTH(W), .DIV_RESET(3)) dut (
        .clock_fpga (clock_fpga),
        .congela_sw (congela_sw),
        .congela    (congela),
        .halt       (halt),
        .mode       (mode),
        .div_load   (div_load),
        .div_value  (div_value),
        .step       (step),
        .new_clock  (new_clock),
        .led_pc     (led_pc),
        .div_err    (div_err)
    );

    always #5 clock_fpga = ~clock_fpga;

    task automatic edge_cyc();
        @(posedge clock_fpga);
        @(negedge clock_fpga);
    endtask

    task automatic test_reset();
        congela_sw = 1'b1; congela = 1'b0; halt = 1'b0; div_load = 1'b0;
        step = 1'b0; mode = 2'b00; div_value = '0;
        edge_cyc();
        edge_cyc();
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_clock got %0b exp 0", new_clock); end
        checks++; if (led_pc !== 1'b0) begin errors++; $display("[TB] FAIL reset_led_pc got %0b exp 0", led_pc); end
        checks++; if (div_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_err got %0b exp 0", div_err); end
        checks++; if (dut.cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", dut.cnt); end
        checks++; if (dut.div_q !== 4'd3) begin errors++; $display("[TB] FAIL reset_div_q got %0d exp 3", dut.div_q); end
        congela_sw = 1'b0;
    endtask

    task automatic test_pulse();
        logic exp_nc;
        for (int k = 1; k <= 12; k++) begin
            edge_cyc();
            exp_nc = (k % 4 == 0);
            checks++; if (new_clock !== exp_nc) begin errors++; $display("[TB] FAIL pulse_nc edge %0d got %0b exp %0b", k, new_clock, exp_nc); end
            checks++; if (led_pc !== ~exp_nc) begin errors++; $display("[TB] FAIL pulse_led edge %0d got %0b exp %0b", k, led_pc, ~exp_nc); end
        end
    endtask

    task automatic test_square();
        logic exp_nc;
        mode = 2'b01;
        edge_cyc();
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL square_modechg_nc got %0b exp 0", new_clock); end
        for (int k = 1; k <= 16; k++) begin
            edge_cyc();
            exp_nc = ((k / 4) % 2 == 1);
            checks++; if (new_clock !== exp_nc) begin errors++; $display("[TB] FAIL square_nc edge %0d got %0b exp %0b", k, new_clock, exp_nc); end
        end
    endtask

    task automatic test_load();
        logic exp_nc;
        mode = 2'b00;
        edge_cyc();
        for (int k = 1; k <= 4; k++) edge_cyc();
        div_load = 1'b1; div_value = 4'd1;
        edge_cyc();
        div_load = 1'b0;
        checks++; if (dut.div_q !== 4'd1) begin errors++; $display("[TB] FAIL load_div_q got %0d exp 1", dut.div_q); end
        checks++; if (dut.cnt !== 4'd0) begin errors++; $display("[TB] FAIL load_cnt got %0d exp 0", dut.cnt); end
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL load_nc got %0b exp 0", new_clock); end
        for (int k = 6; k <= 11; k++) begin
            edge_cyc();
            exp_nc = (k % 2 == 1);
            checks++; if (new_clock !== exp_nc) begin errors++; $display("[TB] FAIL load_nc edge %0d got %0b exp %0b", k, new_clock, exp_nc); end
        end
        div_load = 1'b1; div_value = 4'd0;
        edge_cyc();
        div_load = 1'b0;
        checks++; if (div_err !== 1'b1) begin errors++; $display("[TB] FAIL load0_err got %0b exp 1", div_err); end
        checks++; if (dut.div_q !== 4'd1) begin errors++; $display("[TB] FAIL load0_div_q got %0d exp 1", dut.div_q); end
        for (int k = 1; k <= 4; k++) begin
            edge_cyc();
            exp_nc = (k % 2 == 0);
            checks++; if (div_err !== 1'b0) begin errors++; $display("[TB] FAIL load0_err_clear edge %0d got %0b exp 0", k, div_err); end
            checks++; if (new_clock !== exp_nc) begin errors++; $display("[TB] FAIL load0_period edge %0d got %0b exp %0b", k, new_clock, exp_nc); end
        end
    endtask

    task automatic test_halt_freeze();
        div_load = 1'b1; div_value = 4'd3;
        edge_cyc();
        div_load = 1'b0;
        edge_cyc();
        edge_cyc();
        halt = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            edge_cyc();
            checks++; if (dut.cnt !== 4'd2) begin errors++; $display("[TB] FAIL halt_cnt cycle %0d got %0d exp 2", k, dut.cnt); end
            checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL halt_nc cycle %0d got %0b exp 0", k, new_clock); end
            checks++; if (led_pc !== 1'b0) begin errors++; $display("[TB] FAIL halt_led cycle %0d got %0b exp 0", k, led_pc); end
        end
        halt = 1'b0;
        edge_cyc();
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL halt_resume1 got %0b exp 0", new_clock); end
        edge_cyc();
        checks++; if (new_clock !== 1'b1) begin errors++; $display("[TB] FAIL halt_resume2 got %0b exp 1", new_clock); end
        edge_cyc();
        edge_cyc();
        congela = 1'b1;
        edge_cyc();
        congela = 1'b0;
        checks++; if (dut.cnt !== 4'd0) begin errors++; $display("[TB] FAIL freeze_cnt got %0d exp 0", dut.cnt); end
        checks++; if (dut.div_q !== 4'd3) begin errors++; $display("[TB] FAIL freeze_div_q got %0d exp 3", dut.div_q); end
        checks++; if (led_pc !== 1'b0) begin errors++; $display("[TB] FAIL freeze_led got %0b exp 0", led_pc); end
    endtask

    task automatic test_step();
        logic exp_nc;
        mode = 2'b10;
        edge_cyc();
        step = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            edge_cyc();
            exp_nc = (k == 1);
            checks++; if (new_clock !== exp_nc) begin errors++; $display("[TB] FAIL step_nc cycle %0d got %0b exp %0b", k, new_clock, exp_nc); end
            checks++; if (led_pc !== 1'b0) begin errors++; $display("[TB] FAIL step_led cycle %0d got %0b exp 0", k, led_pc); end
        end
        step = 1'b0;
        edge_cyc();
        checks++; if (dut.cnt !== 4'd0) begin errors++; $display("[TB] FAIL step_cnt got %0d exp 0", dut.cnt); end
        halt = 1'b1; step = 1'b1;
        edge_cyc();
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL step_halt got %0b exp 0", new_clock); end
        halt = 1'b0;
        edge_cyc();
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL step_after_halt got %0b exp 0", new_clock); end
        step = 1'b0;
        edge_cyc();
    endtask

    task automatic test_priority();
        mode = 2'b00;
        edge_cyc();
        edge_cyc();
        edge_cyc();
        congela_sw = 1'b1; div_load = 1'b1; div_value = 4'd1;
        edge_cyc();
        congela_sw = 1'b0; div_load = 1'b0;
        checks++; if (dut.div_q !== 4'd3) begin errors++; $display("[TB] FAIL prio_div_q got %0d exp 3", dut.div_q); end
        checks++; if ({new_clock, led_pc, div_err} !== 3'b000) begin errors++; $display("[TB] FAIL prio_outputs got %b exp 000", {new_clock, led_pc, div_err}); end
        edge_cyc();
        edge_cyc();
        edge_cyc();
        checks++; if (dut.cnt !== 4'd3) begin errors++; $display("[TB] FAIL prio_precnt got %0d exp 3", dut.cnt); end
        mode = 2'b01;
        edge_cyc();
        checks++; if (new_clock !== 1'b0) begin errors++; $display("[TB] FAIL modechg_term_nc got %0b exp 0", new_clock); end
        checks++; if (dut.cnt !== 4'd0) begin errors++; $display("[TB] FAIL modechg_term_cnt got %0d exp 0", dut.cnt); end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_square();
        test_load();
        test_halt_freeze();
        test_step();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
